// File: rtl/bagging_sched_pkg.sv
// bagging_pkg: shared encodings, widths and FSM states for the bagging scheduler.
// Rev 1.0
`default_nettype none

package bagging_pkg;

    localparam logic [1:0] CLS_POS = 2'b01;
    localparam logic [1:0] CLS_NEG = 2'b11;

    localparam int FEAT_W = 2;
    localparam int WGT_W  = 9;
    localparam int ACC_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_VOTE      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // Address width that stays legal when a depth of 1 is requested.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bagging_sched_vote_acc.sv
// vote_acc: signed +/-1 vote accumulator with clear, add-enable and sign output.
// Rev 1.0
`default_nettype none

module vote_acc
    import bagging_pkg::*;
#(
    parameter int OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic             i_neg,
    output logic [OUT_W-1:0] o_sum,
    output logic             o_neg
);

    localparam logic signed [ACC_W-1:0] c_one = {{(ACC_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= i_neg ? (r_sum - c_one) : (r_sum + c_one);
        end
    end

    assign o_sum = r_sum[OUT_W-1:0];
    assign o_neg = r_sum[ACC_W-1];

endmodule

`default_nettype wire

// File: rtl/bagging_sched.sv
// bagging_sched: time-multiplexes one linear-classifier engine across bagged learners
// and emits the majority vote. Rev 1.0
`default_nettype none

module bagging_sched
    import bagging_pkg::*;
#(
    parameter int N_LEARNERS = 5,
    parameter int N_FEAT     = 30,
    parameter int TIMEOUT    = 64
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      busy,
    output logic [clog2_min1(N_FEAT)-1:0]             feat_addr,
    input  logic [FEAT_W-1:0]                         feat_q,
    output logic [clog2_min1(N_LEARNERS*N_FEAT)-1:0]  w_addr,
    input  logic [WGT_W-1:0]                          w_q,
    output logic [clog2_min1(N_LEARNERS)-1:0]         b_addr,
    input  logic [WGT_W-1:0]                          b_q,
    output logic                                      eng_en,
    output logic [FEAT_W-1:0]                         eng_data,
    output logic [WGT_W-1:0]                          eng_weight,
    output logic [WGT_W-1:0]                          eng_bias,
    input  logic [1:0]                                eng_result,
    input  logic                                      eng_ready,
    output logic [1:0]                                class_out,
    output logic [4:0]                                vote_sum,
    output logic                                      done,
    output logic                                      err
);

    localparam int FA_W = clog2_min1(N_FEAT);
    localparam int WA_W = clog2_min1(N_LEARNERS * N_FEAT);
    localparam int BA_W = clog2_min1(N_LEARNERS);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [FA_W-1:0] c_k_last  = FA_W'(N_FEAT - 1);
    localparam logic [BA_W-1:0] c_l_last  = BA_W'(N_LEARNERS - 1);
    localparam logic [WA_W-1:0] c_w_step  = WA_W'(N_FEAT);
    localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [FA_W-1:0]   r_k;
    logic [BA_W-1:0]   r_l;
    logic [WA_W-1:0]   r_wbase;
    logic [TO_W-1:0]   r_to;
    logic [1:0]        r_class;
    logic [4:0]        r_sum;

    logic              w_eng_en;
    logic              w_done;
    logic              w_err;
    logic              w_clr;
    logic              w_add;
    logic              w_timeout;
    logic [4:0]        w_acc_sum;
    logic              w_acc_neg;
    logic [1:0]        w_cls;

    vote_acc #(
        .OUT_W (5)
    ) u_vote_acc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_add (w_add),
        .i_neg (eng_result != CLS_POS),
        .o_sum (w_acc_sum),
        .o_neg (w_acc_neg)
    );

    assign w_timeout = (r_to == c_timeout);
    assign w_cls     = w_acc_neg ? CLS_NEG : CLS_POS;

    always_comb begin
        w_next   = r_state;
        w_eng_en = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        w_clr    = 1'b0;
        w_add    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_eng_en = 1'b1;
                w_next   = ST_WAIT_LOW;
            end
            // Ready must drop first so a stale ready from the previous learner is not taken as a result.
            ST_WAIT_LOW: begin
                if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end else if (!eng_ready) begin
                    w_next = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end else if (eng_ready) begin
                    w_next = ST_VOTE;
                end
            end
            ST_VOTE: begin
                w_add  = 1'b1;
                w_next = (r_l == c_l_last) ? ST_FINISH : ST_LAUNCH;
            end
            ST_FINISH: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_l     <= '0;
            r_wbase <= '0;
            r_to    <= '0;
            r_class <= CLS_POS;
            r_sum   <= '0;
        end else begin
            r_state <= w_next;

            // k is 0 in the launch cycle and saturates at the last feature.
            case (r_state)
                ST_LAUNCH, ST_WAIT_LOW, ST_WAIT_HIGH: begin
                    if (r_k != c_k_last) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: r_k <= '0;
            endcase

            if (r_state == ST_LAUNCH) begin
                r_to <= c_to_one;
            end else if ((r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) && !w_timeout) begin
                r_to <= r_to + 1'b1;
            end

            if (r_state == ST_IDLE && start) begin
                r_l     <= '0;
                r_wbase <= '0;
            end else if (r_state == ST_VOTE && r_l != c_l_last) begin
                r_l     <= r_l + 1'b1;
                r_wbase <= r_wbase + c_w_step;
            end

            if (r_state == ST_FINISH) begin
                r_class <= w_cls;
                r_sum   <= w_acc_sum;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign eng_en     = w_eng_en;
    assign done       = w_done;
    assign err        = w_err;
    assign feat_addr  = r_k;
    assign w_addr     = r_wbase + WA_W'(r_k);
    assign b_addr     = r_l;
    assign eng_data   = feat_q;
    assign eng_weight = w_q;
    assign eng_bias   = b_q;
    // The final result is visible in the done cycle itself, then held until the next run.
    assign class_out  = (r_state == ST_FINISH) ? w_cls : r_class;
    assign vote_sum   = (r_state == ST_FINISH) ? w_acc_sum : r_sum;

endmodule

`default_nettype wire

// File: tb/tb_bagging_sched.sv
// tb_bagging_sched: directed bench for bagging_sched with a behavioural engine and memories.
// Rev 1.0
`default_nettype none

module tb_bagging_sched;
    import bagging_pkg::*;

    localparam int NF = 30;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // DUT with 5 learners
    logic       start5, busy5, en5, rdy5, done5, err5;
    logic [4:0] fa5;
    logic [7:0] wa5;
    logic [2:0] ba5;
    logic [1:0] fq5, ed5, res5, cls5;
    logic [8:0] wq5, bq5, ew5, eb5;
    logic [4:0] vs5;

    // DUT with 4 learners
    logic       start4, busy4, en4, rdy4, done4, err4;
    logic [4:0] fa4;
    logic [6:0] wa4;
    logic [1:0] ba4;
    logic [1:0] fq4, ed4, res4, cls4;
    logic [8:0] wq4, bq4, ew4, eb4;
    logic [4:0] vs4;

    bagging_sched #(.N_LEARNERS(5), .N_FEAT(NF), .TIMEOUT(64)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .busy(busy5),
        .feat_addr(fa5), .feat_q(fq5), .w_addr(wa5), .w_q(wq5), .b_addr(ba5), .b_q(bq5),
        .eng_en(en5), .eng_data(ed5), .eng_weight(ew5), .eng_bias(eb5),
        .eng_result(res5), .eng_ready(rdy5),
        .class_out(cls5), .vote_sum(vs5), .done(done5), .err(err5)
    );

    bagging_sched #(.N_LEARNERS(4), .N_FEAT(NF), .TIMEOUT(64)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4),
        .feat_addr(fa4), .feat_q(fq4), .w_addr(wa4), .w_q(wq4), .b_addr(ba4), .b_q(bq4),
        .eng_en(en4), .eng_data(ed4), .eng_weight(ew4), .eng_bias(eb4),
        .eng_result(res4), .eng_ready(rdy4),
        .class_out(cls4), .vote_sum(vs4), .done(done4), .err(err4)
    );

    // Memories: each word holds its own address, so returned data reveals alignment.
    always @(posedge clk) begin
        fq5 <= fa5[1:0];
        wq5 <= {1'b0, wa5};
        bq5 <= {6'd0, ba5};
    end
    assign fq4 = 2'b00;
    assign wq4 = 9'd0;
    assign bq4 = 9'd0;

    // Engine models: result after NF+3 edges past the launch edge, chosen per learner.
    logic [1:0] tab5 [0:4];
    logic [1:0] tab4 [0:3];
    logic       stale5, never5;
    int         e5_cnt, e4_cnt;
    logic [2:0] e5_lrn;
    logic [1:0] e4_lrn;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy5 <= 1'b0; res5 <= CLS_POS; e5_cnt <= 0; e5_lrn <= '0;
        end else if (en5) begin
            e5_cnt <= 1;
            e5_lrn <= ba5;
            if (!stale5) rdy5 <= 1'b0;
        end else if (e5_cnt != 0) begin
            e5_cnt <= e5_cnt + 1;
            if (stale5 && e5_cnt == 2) rdy5 <= 1'b0;
            if (e5_cnt == NF + 3) begin
                e5_cnt <= 0;
                if (!never5) begin
                    rdy5 <= 1'b1;
                    res5 <= tab5[e5_lrn];
                end
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy4 <= 1'b0; res4 <= CLS_POS; e4_cnt <= 0; e4_lrn <= '0;
        end else if (en4) begin
            e4_cnt <= 1;
            e4_lrn <= ba4;
            rdy4   <= 1'b0;
        end else if (e4_cnt != 0) begin
            e4_cnt <= e4_cnt + 1;
            if (e4_cnt == NF + 3) begin
                e4_cnt <= 0;
                rdy4   <= 1'b1;
                res4   <= tab4[e4_lrn];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         rn_cyc, rn_nd, rn_ner, rn_nen;
    logic [4:0] rn_vs;
    logic [1:0] rn_cls;
    logic       rn_busy1;
    logic [4:0] sw_f [0:30];
    logic [7:0] sw_w [0:30];
    logic [2:0] sw_b [0:30];
    logic [8:0] sw_e [0:30];

    // One start pulse, then observe every negedge until 40 cycles past done/err (bounded).
    task automatic run(input bit sel, input bit extra, input bit sweep);
        int sw;
        sw = -1;
        rn_cyc = 0; rn_nd = 0; rn_ner = 0; rn_nen = 0;
        rn_vs = 'x; rn_cls = 'x; rn_busy1 = 1'b1;
        if (sel) start4 = 1'b1; else start5 = 1'b1;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (t == 1 || t == 11) begin start4 = 1'b0; start5 = 1'b0; end
            if (extra && t == 10) begin
                if (sel) start4 = 1'b1; else start5 = 1'b1;
            end
            if (sel ? done4 : done5) rn_nd++;
            if (sel ? err4 : err5) rn_ner++;
            if (sel ? en4 : en5) rn_nen++;
            if (rn_cyc == 0 && (sel ? (done4 | err4) : (done5 | err5))) begin
                rn_cyc = t;
                rn_vs  = sel ? vs4 : vs5;
                rn_cls = sel ? cls4 : cls5;
            end else if (rn_cyc != 0 && t == rn_cyc + 1) begin
                rn_busy1 = sel ? busy4 : busy5;
            end
            if (sweep) begin
                if (sw < 0 && en5 && ba5 == 3'd2) sw = 0;
                if (sw >= 0 && sw <= 30) begin
                    sw_f[sw] = fa5; sw_w[sw] = wa5; sw_b[sw] = ba5; sw_e[sw] = ew5;
                    sw++;
                end
            end
            if (rn_cyc != 0 && t >= rn_cyc + 40) break;
        end
    endtask

    initial begin
        int   wt;
        logic got;
        rst = 1'b0; start5 = 1'b0; start4 = 1'b0; stale5 = 1'b0; never5 = 1'b0;
        tab5 = '{CLS_POS, CLS_POS, CLS_NEG, CLS_POS, CLS_NEG};
        tab4 = '{CLS_POS, CLS_NEG, CLS_POS, CLS_NEG};
        repeat (2) @(negedge clk);

        chk("rst_busy", busy5, 0);
        chk("rst_eng_en", en5, 0);
        chk("rst_done", done5, 0);
        chk("rst_err", err5, 0);
        chk("rst_class", cls5, 2'b01);
        chk("rst_vote_sum", vs5, 0);
        chk("rst_feat_addr", fa5, 0);
        chk("rst_w_addr", wa5, 0);
        chk("rst_b_addr", ba5, 0);

        rst = 1'b1;
        @(negedge clk);

        // Votes +1,+1,-1,+1,-1 with learner-2 address sweep
        run(1'b0, 1'b0, 1'b1);
        chk("n5_done_cycle", rn_cyc, 181);
        chk("n5_done_pulses", rn_nd, 1);
        chk("n5_err_pulses", rn_ner, 0);
        chk("n5_launches", rn_nen, 5);
        chk("n5_vote_sum", rn_vs, 5'h01);
        chk("n5_class", rn_cls, 2'b01);
        chk("n5_busy_after", rn_busy1, 0);
        chk("n5_vote_sum_held", vs5, 5'h01);
        for (int j = 0; j < NF; j++) begin
            chk($sformatf("sweep_feat_addr_%0d", j), sw_f[j], j);
            chk($sformatf("sweep_w_addr_%0d", j), sw_w[j], 60 + j);
            chk($sformatf("sweep_b_addr_%0d", j), sw_b[j], 2);
        end
        for (int j = 1; j <= NF; j++) begin
            chk($sformatf("sweep_eng_weight_%0d", j), sw_e[j], 60 + j - 1);
        end
        chk("sweep_feat_hold", sw_f[30], 29);
        chk("sweep_w_hold", sw_w[30], 89);

        // Stale ready held 2 cycles after each launch; votes -1,+1,-1,-1,+1
        stale5 = 1'b1;
        tab5 = '{CLS_NEG, CLS_POS, CLS_NEG, CLS_NEG, CLS_POS};
        run(1'b0, 1'b0, 1'b0);
        chk("stale_done_cycle", rn_cyc, 181);
        chk("stale_done_pulses", rn_nd, 1);
        chk("stale_launches", rn_nen, 5);
        chk("stale_vote_sum", rn_vs, 5'h1f);
        chk("stale_class", rn_cls, 2'b11);

        // Engine never answers
        stale5 = 1'b0;
        never5 = 1'b1;
        run(1'b0, 1'b0, 1'b0);
        chk("to_err_cycle", rn_cyc, 65);
        chk("to_err_pulses", rn_ner, 1);
        chk("to_done_pulses", rn_nd, 0);
        chk("to_launches", rn_nen, 1);
        chk("to_vote_sum", rn_vs, 5'h1f);
        chk("to_class", rn_cls, 2'b11);
        chk("to_busy_after", rn_busy1, 0);
        chk("to_vote_sum_held", vs5, 5'h1f);

        // Reset while waiting for the engine
        never5 = 1'b0;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        got = 1'b0;
        for (wt = 0; wt < 100 && !got; wt++) begin
            if (dut5.r_state == ST_WAIT_HIGH) got = 1'b1;
            else @(negedge clk);
        end
        chk("mid_reached_wait_high", got, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy5, 0);
        chk("mid_eng_en", en5, 0);
        chk("mid_class", cls5, 2'b01);
        chk("mid_vote_sum", vs5, 0);
        chk("mid_state", dut5.r_state, ST_IDLE);
        chk("mid_w_addr", wa5, 0);
        rst = 1'b1;
        @(negedge clk);

        // Four learners, tie, extra start while busy
        run(1'b1, 1'b1, 1'b0);
        chk("n4_done_cycle", rn_cyc, 145);
        chk("n4_done_pulses", rn_nd, 1);
        chk("n4_err_pulses", rn_ner, 0);
        chk("n4_launches", rn_nen, 4);
        chk("n4_vote_sum", rn_vs, 5'h00);
        chk("n4_class", rn_cls, 2'b01);
        chk("n4_busy_after", rn_busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bagging_sched.md
# bagging_sched

Time-multiplexes one shared linear-classifier engine (30-feature MAC, bias add, sign decision) across `N_LEARNERS` bagged base learners and produces the majority-vote class for one sample. It sits between the sample, weight and bias memories and the engine:
- Fetches each learner's weights and bias.
- Streams the sample features.
- Launches the engine once per learner and collects each ±1 result.
- Emits the ensemble decision with a one-cycle valid pulse.

## Interface
Parameters:
- `N_LEARNERS`, 5, number of base learners (1..15)
- `N_FEAT`, 30, features per sample; equals engine MAC length
- `TIMEOUT`, 64, max cycles from engine launch to engine ready before abort

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to classify the sample in memory; ignored while `busy`
- `busy`  out  1  high from the accepted `start` until the cycle after `done`/`err`
- `feat_addr`  out  clog2(N_FEAT)  sample-memory address
- `feat_q`  in  2  signed feature, synchronous read, latency 1
- `w_addr`  out  clog2(N_LEARNERS*N_FEAT)  weight-memory address
- `w_q`  in  9  signed weight, latency 1
- `b_addr`  out  clog2(N_LEARNERS)  bias-memory address
- `b_q`  in  9  signed bias, latency 1
- `eng_en`  out  1  engine start pulse
- `eng_data`  out  2  equals `feat_q`
- `eng_weight`  out  9  equals `w_q`
- `eng_bias`  out  9  equals `b_q`
- `eng_result`  in  2  engine decision: 2'b01 = +1, 2'b11 = −1
- `eng_ready`  in  1  engine result valid; level signal, falls after the engine accepts `eng_en`
- `class_out`  out  2  ensemble decision, same encoding as `eng_result`
- `vote_sum`  out  5  signed sum of learner votes
- `done`  out  1  one-cycle pulse; `class_out`/`vote_sum` valid from this cycle until the next `start`
- `err`  out  1  one-cycle pulse on timeout abort

## Operation
- Reset values: `busy`, `eng_en`, `done`, `err` = 0; `class_out` = 2'b01; `vote_sum` = 0; all addresses 0; state IDLE.
- FSM states: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, VOTE, FINISH.
  - IDLE: when `start` is high, clear the learner index `l` and the vote accumulator, set `busy`, and go to LAUNCH.
  - LAUNCH: assert `eng_en` for exactly one cycle and go to WAIT_LOW. The feature counter `k` starts at 0 in this cycle.
  - WAIT_LOW: wait for `eng_ready` = 0. This confirms the engine consumed the launch and is not showing the previous learner's stale ready.
  - WAIT_HIGH: wait for `eng_ready` = 1, then go to VOTE.
  - VOTE: accumulator += +1 if `eng_result` = 2'b01, −1 otherwise. If `l` = N_LEARNERS−1, go to FINISH; else `l`++ and go to LAUNCH.
  - FINISH: `class_out` = 2'b01 if the sum ≥ 0 (ties, even N only, resolve to +1), else 2'b11. Latch `vote_sum`, pulse `done`, go to IDLE with `busy` low the next cycle.
- Address streaming:
  - `feat_addr` = k and `w_addr` = l·N_FEAT + k during cycle k after launch, for k = 0..N_FEAT−1.
  - After k reaches N_FEAT−1, both addresses hold at the last value.
  - `b_addr` = l throughout the learner's run.
- Timeout:
  - A cycle counter restarts at LAUNCH and counts during WAIT_LOW and WAIT_HIGH.
  - Reaching TIMEOUT aborts the run: pulse `err`, return to IDLE, leave `class_out`/`vote_sum` unchanged, no `done`.
- `start` while `busy` is dropped, not queued.
- Reset mid-run returns to IDLE immediately. The engine must also be reset by the same `rst`.

## Timing
- Engine contract:
  - The engine samples `eng_en` at edge E0.
  - It accumulates `eng_data`·`eng_weight` at edges E1..E(N_FEAT).
  - It adds `eng_bias` after the last MAC.
  - It asserts `eng_ready` with the result about 3 cycles after E(N_FEAT).
  - It restarts its feature counter on every launch.
- Memory alignment: feature k is addressed in cycle k (the `eng_en` cycle is cycle 0), the memory returns it in cycle k+1, and the engine samples it at E(k+1).
- `eng_data`, `eng_weight` and `eng_bias` are combinational pass-through; no extra register.
- Per-learner latency: 1 (LAUNCH) + engine run + 1 (VOTE) cycles. With N_FEAT = 30 this is 36 cycles, so a 5-learner run takes about 181 cycles from `start` to `done`.
- `done` and `err` are never high in the same cycle.

## Structure
- Shared package `bagging_pkg`:
  - Encodings `CLS_POS` = 2'b01 and `CLS_NEG` = 2'b11.
  - Data widths: 2 (feature), 9 (weight/bias), 12 (accumulator).
  - FSM state enumeration.
- One sub-module, `vote_acc`: signed ±1 accumulator with clear, add-enable and sign output. The scheduler FSM, address counters and timeout counter stay in the top level.

## Test plan
- Reset mid-run: assert `rst` while in WAIT_HIGH → next cycle `busy` = 0, `eng_en` = 0, `class_out` = 2'b01, `vote_sum` = 0, state IDLE.
- N = 5, engine model returns +1,+1,−1,+1,−1 → `vote_sum` = +1, `class_out` = 2'b01, exactly one `done` pulse, exactly 5 `eng_en` pulses.
- Address sweep, learner 2: `w_addr` runs 60..89 and `feat_addr` runs 0..29 in consecutive cycles starting at the `eng_en` cycle; `b_addr` = 2 throughout.
- Stale ready: engine model holds `eng_ready` = 1 for 2 cycles after `eng_en` → scheduler votes only after the low→high transition, and exactly 5 votes are counted.
- Timeout: engine never raises `eng_ready`, TIMEOUT = 64 → `err` pulses 64 cycles after LAUNCH, no `done`, `vote_sum` unchanged.
- `start` pulsed while `busy`, and N = 4 with votes +1,−1,+1,−1 → the extra start is ignored; `vote_sum` = 0 and `class_out` = 2'b01 (tie resolves to +1).
